mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 multiplexer datapath between four requesters.
- Drives the mux select lines (s1, s0) and a one-hot grant vector.
- Sits directly in front of the mux: requester k's data is wired to mux input ik, and sel drives {s1,s0}.
- Guarantees the select lines never change while a grant is active, and that every requester is eventually served.

Parameters:
- MAX_HOLD, 16, cycles a grant may be held while others wait (used only with the optional feature); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; the requester holds it high until its transfer is done.
- grant  output  4  one-hot grant, or all zeros when idle.
- sel  output  2  mux select; sel[1] drives s1, sel[0] drives s0; equals the index of the granted requester.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset (async, rst=1):
  - Outputs: grant=4'b0000, sel=2'b00, busy=0.
  - Internal state: state=IDLE, last-grant pointer ptr=3 (so requester 0 wins first), hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, BUSY.
- IDLE:
  - If req==0: stay in IDLE; sel holds its last value.
  - Otherwise, on the next edge, pick the first asserted req scanning indices ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Then: grant=onehot(k), sel=k, ptr=k, hold_cnt=0, busy=1, state goes to BUSY.
  - Latency: req rising at edge N is seen at edge N+1; grant/sel are valid after edge N+1.
- BUSY:
  - While req[ptr]=1: grant, sel and busy hold steady. sel must not change while busy=1.
  - When req[ptr]=0 at an edge: grant=0, busy=0, state goes to IDLE. sel keeps its value.
  - Handoff: the old owner releases at edge M; the next grant appears at edge M+1 at the earliest. This leaves one dead cycle with grant=0 for mux settling.
- Simultaneous events:
  - Requests from non-owners during BUSY are only recorded; they are arbitrated in IDLE.
  - A requester that drops and re-raises req in the dead cycle competes normally; it has the lowest priority because ptr points to it.
- Fairness: with all four req held high continuously, the grant order is 0,1,2,3,0,...
- Width rules:
  - ptr is 2 bits and wraps modulo 4.
  - hold_cnt saturates at MAX_HOLD-1 and never wraps.
- Invariants:
  - grant is always one-hot or zero.
  - busy == |grant.
  - When busy=1, grant[sel]=1.

Optional Feature:
- Macro: MUX4_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt increments every BUSY cycle.
  - When hold_cnt==MAX_HOLD-1 and any other req bit is high, the grant is revoked at the next edge (grant=0, state goes to IDLE). ptr is unchanged, so the revoked owner gets the lowest priority in the next arbitration.
  - If no other request is pending, hold_cnt saturates and the grant is kept.
- Not defined:
  - No hold_cnt logic.
  - A grant is held until the owner drops req, regardless of duration.

Test Plan:
- Reset check: assert rst mid-grant (grant=4'b0100) between clock edges -> grant=0, sel=00 and busy=0 immediately; after release with req=4'b1111 -> first grant=4'b0001, sel=00.
- Single requester: req=4'b1000 held 5 cycles then dropped -> grant=4'b1000 and sel=11 one edge after req rises, stable 5 cycles; grant=0 one edge after the drop.
- Round robin: req=4'b1111, each owner drops its req for one cycle after 3 granted cycles -> grant sequence 0001,0010,0100,1000,0001 with exactly one dead cycle between grants.
- Priority after release: owner 2 releases, then req=4'b0101 is asserted -> requester 0 granted next (scan 3,0,1,2), sel=00.
- Sel stability: randomize other req bits while requester 1 holds its grant for 20 cycles -> sel stays 01 and grant stays 0010 throughout.
- With MUX4_ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011 both held -> grant 0001 for 4 cycles, 1 dead cycle, grant 0010 for 4 cycles, alternating. With only req=4'b0001 held -> grant is never revoked.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between four requesters and the
// round-robin arbiter that steers a shared 4-to-1 mux.
//   master - requester side: drives req, observes grant/sel/busy
//   slave  - arbiter side: observes req, drives grant/sel/busy
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter in front of a shared 4-to-1 mux.
// sel[1:0] drives the mux {s1,s0}; grant is one-hot (or zero when idle).
// Once a grant is issued, sel and grant stay frozen until the owner drops
// req. Every handoff passes through one dead cycle with grant=0 so the mux
// can settle before the next owner sees it.
// All outputs come straight from flops.
// Optional macro MUX4_ARB_TIMEOUT_EN: revokes a grant held for MAX_HOLD
// cycles while another requester waits.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mux4_rr_arbiter_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             others_waiting;
`endif

    // Reject parameter combinations where the hold counter could wrap.
    generate
        if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_bad_params
            $error("mux4_rr_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
        end
    endgenerate

    // Round-robin pick: first asserted req scanning ptr+1, ptr+2, ptr+3, ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    // Someone other than the current owner is asking for the mux.
    always_comb begin
        others_waiting = |(bus.req & ~grant_q);
    end
`endif

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
`ifdef MUX4_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    ptr_d   = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (!bus.req[ptr_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
`ifdef MUX4_ARB_TIMEOUT_EN
                else if ((hold_cnt_q == HOLD_LAST) && others_waiting) begin
                    // ptr stays on the revoked owner so it scans last next time.
                    state_d    = IDLE;
                    grant_d    = 4'b0000;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
                else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
        endcase
    end

    // State and output registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
`ifdef MUX4_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed bench for mux4_rr_arbiter with hand-computed
// expected grant/sel/busy values. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the edge.
// Built with MUX4_ARB_TIMEOUT_EN, the bench also walks the timeout sequence
// (the DUT is instantiated with MAX_HOLD=4).
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mux4_rr_arbiter_if arb_if ();

    mux4_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_if)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request vector.
    task automatic applyStimulus(input logic [3:0] r);
        arb_if.req = r;
    endtask

    // Compare grant, sel and busy against expected values.
    task automatic checkOutput(input string tag, input logic [3:0] exp_grant,
                               input logic [1:0] exp_sel, input logic exp_busy);
        checks++;
        assert (arb_if.grant === exp_grant) else begin
            errors++;
            $error("[TB] FAIL %s.grant observed %b expected %b", tag, arb_if.grant, exp_grant);
        end
        checks++;
        assert (arb_if.sel === exp_sel) else begin
            errors++;
            $error("[TB] FAIL %s.sel observed %b expected %b", tag, arb_if.sel, exp_sel);
        end
        checks++;
        assert (arb_if.busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s.busy observed %b expected %b", tag, arb_if.busy, exp_busy);
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [3:0] exp_g;
        logic [3:0] rnd;

        rst = 1'b1;
        applyStimulus(4'b0000);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("reset", 4'b0000, 2'b00, 1'b0);

        // ptr=3 after reset, so only requester 2 asking wins on the next edge.
        rst = 1'b0;
        applyStimulus(4'b0100);
        tick();
        checkOutput("pre_reset_grant", 4'b0100, 2'b10, 1'b1);

        // Reset between edges must drop the grant immediately.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 4'b0000, 2'b00, 1'b0);
        applyStimulus(4'b1111);
        rst = 1'b0;
        tick();
        checkOutput("first_after_reset", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0000);
        tick();
        checkOutput("release0", 4'b0000, 2'b00, 1'b0);

        // Single requester 3 holds for five cycles, then drops.
        $display("[TB] single requester");
        applyStimulus(4'b1000);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("single_hold", 4'b1000, 2'b11, 1'b1);
            if (i < 4) tick();
        end
        applyStimulus(4'b0000);
        tick();
        checkOutput("single_drop", 4'b0000, 2'b11, 1'b0);

        // Round robin: every owner keeps its grant 3 cycles then pulses req low.
        $display("[TB] round robin");
        applyStimulus(4'b1111);
        tick();
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            checkOutput("rr_grant_c1", exp_g, 2'(n % 4), 1'b1);
            tick();
            checkOutput("rr_grant_c2", exp_g, 2'(n % 4), 1'b1);
            tick();
            checkOutput("rr_grant_c3", exp_g, 2'(n % 4), 1'b1);
            applyStimulus(~exp_g);
            tick();
            checkOutput("rr_dead", 4'b0000, 2'(n % 4), 1'b0);
            applyStimulus(4'b1111);
            tick();
        end
        checkOutput("rr_wrap_next", 4'b0010, 2'b01, 1'b1);

        // Hand the mux to requester 2, release, then 0 and 2 both ask.
        $display("[TB] priority after release");
        applyStimulus(4'b0100);
        tick();
        checkOutput("to2_dead", 4'b0000, 2'b01, 1'b0);
        tick();
        checkOutput("to2_grant", 4'b0100, 2'b10, 1'b1);
        applyStimulus(4'b0000);
        tick();
        checkOutput("owner2_release", 4'b0000, 2'b10, 1'b0);
        applyStimulus(4'b0101);
        tick();
        checkOutput("prio_after_release", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0000);
        tick();
        checkOutput("prio_release", 4'b0000, 2'b00, 1'b0);

        // Requester 1 holds 20 cycles while other bits toggle.
        $display("[TB] sel stability");
        applyStimulus(4'b0010);
        tick();
        checkOutput("stable_start", 4'b0010, 2'b01, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rnd = 4'($urandom);
`ifdef MUX4_ARB_TIMEOUT_EN
            rnd = 4'b0000;
`endif
            applyStimulus((rnd & 4'b1101) | 4'b0010);
            tick();
            checkOutput("sel_stable", 4'b0010, 2'b01, 1'b1);
        end
        applyStimulus(4'b0000);
        tick();
        checkOutput("stable_release", 4'b0000, 2'b01, 1'b0);

`ifdef MUX4_ARB_TIMEOUT_EN
        // ptr=1: requesters 0 and 1 alternate, each revoked after 4 cycles.
        $display("[TB] timeout");
        applyStimulus(4'b0011);
        tick();
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 4'b0001 : 4'b0010;
            for (int c = 0; c < 4; c++) begin
                checkOutput("timeout_hold", exp_g, 2'(r % 2), 1'b1);
                tick();
            end
            checkOutput("timeout_dead", 4'b0000, 2'(r % 2), 1'b0);
            tick();
        end
        applyStimulus(4'b0001);
        for (int i = 0; i < 10; i++) begin
            checkOutput("timeout_alone", 4'b0001, 2'b00, 1'b1);
            tick();
        end
        applyStimulus(4'b0000);
        tick();
        checkOutput("timeout_release", 4'b0000, 2'b00, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
